// File: rtl/digiota_pkg.sv
// rtl/digiota_pkg.sv - shared state type and default sizing for the OTA scan controller
package digiota_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_REPORT
    } scan_state_t;

    localparam int DEF_NCH    = 4;
    localparam int DEF_SETTLE = 3;
    localparam int DEF_NSAMP  = 5;

endpackage

// File: rtl/digiota_sync2.sv
// rtl/digiota_sync2.sv - two-flop synchronizer for a single asynchronous input
module digiota_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/digiota_scan_ctrl.sv
// rtl/digiota_scan_ctrl.sv - channel sweep, settle, sample and majority-vote sequencer for the shared OTA
module digiota_scan_ctrl
    import digiota_pkg::*;
#(
    parameter int NCH    = DEF_NCH,
    parameter int SETTLE = DEF_SETTLE,
    parameter int NSAMP  = DEF_NSAMP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cont,
    input  logic [NCH-1:0]         ch_mask,
    input  logic                   ota_out,
    output logic [$clog2(NCH)-1:0] ota_sel,
    output logic                   ota_en,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [$clog2(NCH)-1:0] res_ch,
    output logic                   res_bit,
    output logic [3:0]             res_ones,
    output logic                   busy
);

    localparam int CW = $clog2(NCH);
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [3:0]    SAMP_LAST   = 4'(NSAMP - 1);
    localparam logic [3:0]    MAJ         = 4'((NSAMP + 1) / 2);

    scan_state_t   state, state_n;
    logic [CW-1:0]  cur, cur_n;
    logic [NCH-1:0] mask_q, mask_n;
    logic [NCH-1:0] above;
    logic [SW-1:0]  settle_cnt;
    logic [3:0]     samp_cnt;
    logic [3:0]     ones;
    logic           enter_settle;
    logic           ota_sync;

    function automatic logic [CW-1:0] lowest_bit(input logic [NCH-1:0] m);
        lowest_bit = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) lowest_bit = CW'(i);
        end
    endfunction

    digiota_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (ota_out),
        .q   (ota_sync)
    );

    // Channels still pending in this sweep: the latched mask above the current channel.
    always_comb begin
        above = '0;
        for (int i = 0; i < NCH; i++) begin
            above[i] = mask_q[i] && (i > int'(cur));
        end
    end

    always_comb begin
        state_n      = state;
        cur_n        = cur;
        mask_n       = mask_q;
        enter_settle = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (|ch_mask)) begin
                    mask_n       = ch_mask;
                    cur_n        = lowest_bit(ch_mask);
                    state_n      = ST_SETTLE;
                    enter_settle = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) state_n = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (samp_cnt == SAMP_LAST) state_n = ST_REPORT;
            end
            ST_REPORT: begin
                if (res_ready) begin
                    if (|above) begin
                        cur_n        = lowest_bit(above);
                        state_n      = ST_SETTLE;
                        enter_settle = 1'b1;
                    end else if (cont && (|ch_mask)) begin
                        mask_n       = ch_mask;
                        cur_n        = lowest_bit(ch_mask);
                        state_n      = ST_SETTLE;
                        enter_settle = 1'b1;
                    end else begin
                        if (cont) mask_n = ch_mask;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur        <= '0;
            mask_q     <= '0;
            settle_cnt <= '0;
            samp_cnt   <= '0;
            ones       <= '0;
        end else begin
            state  <= state_n;
            cur    <= cur_n;
            mask_q <= mask_n;

            if (enter_settle) begin
                settle_cnt <= '0;
                ones       <= '0;
            end else if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else if (state == ST_SAMPLE) begin
                ones <= ones + {3'b000, ota_sync};
            end

            if (state == ST_SAMPLE) samp_cnt <= samp_cnt + 1'b1;
            else                    samp_cnt <= '0;
        end
    end

    // Result fields read zero outside REPORT so the consumer never sees a partial count.
    assign busy      = (state != ST_IDLE);
    assign ota_en    = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign ota_sel   = busy ? cur : '0;
    assign res_valid = (state == ST_REPORT);
    assign res_ch    = res_valid ? cur : '0;
    assign res_ones  = res_valid ? ones : 4'd0;
    assign res_bit   = res_valid && (ones >= MAJ);

endmodule

// File: doc/digiota_scan_ctrl.md
# digiota_scan_ctrl

Sequencer that time-shares the single digital OTA/comparator cell across up to `NCH` differential input channels. It selects a channel and enables the cell, waits a settle interval, then takes `NSAMP` samples of the cell output through a synchronizer. It majority-votes the samples and hands one result per channel to the consumer over a valid/ready handshake. It sits between the analog input mux, which it drives, and the digital back end.

## Interface
Parameters:
- `NCH`, 4: number of input channels, 2..16.
- `SETTLE`, 3: cycles between channel select/enable and first sample; ≥2 (covers synchronizer latency).
- `NSAMP`, 5: samples per conversion; odd, 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse/level; begins a sweep when in IDLE.
- `cont`  in  1  continuous mode; sampled at the end of each sweep.
- `ch_mask`  in  NCH  channels to convert; captured at sweep start.
- `ota_out`  in  1  raw OTA output, asynchronous to `clk`.
- `ota_sel`  out  clog2(NCH)  mux select for the OTA inputs.
- `ota_en`  out  1  OTA enable.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_ch`  out  clog2(NCH)  channel of the result.
- `res_bit`  out  1  majority decision (1 = Vip > Vin).
- `res_ones`  out  4  count of samples that read 1.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, REPORT.
- IDLE:
  - If `start`=1 and `ch_mask`≠0: latch the mask into `mask_q`, set `cur` to the lowest set bit, and go to SETTLE.
  - If `start`=1 and `ch_mask`=0: ignore, stay IDLE.
- SETTLE:
  - `ota_sel`=`cur`, `ota_en`=1.
  - Count `SETTLE` cycles, then go to SAMPLE.
  - Clear `ones` on entry.
- SAMPLE:
  - `ota_en`=1.
  - Each cycle, add the synchronized `ota_out` to `ones`.
  - After `NSAMP` cycles go to REPORT.
- REPORT:
  - `ota_en`=0, `res_valid`=1, `res_ch`=`cur`, `res_ones`=`ones`, `res_bit`=(`ones` ≥ (`NSAMP`+1)/2).
  - Outputs are stable until the handshake `res_valid`&`res_ready`.
  - On handshake, if a higher set bit remains in `mask_q`: `cur` takes the next set bit, go to SETTLE.
  - On handshake with the sweep complete:
    - `cont`=1: reload `mask_q` from `ch_mask`. If nonzero, `cur` takes its lowest bit and the FSM goes to SETTLE; if zero, go to IDLE.
    - `cont`=0: go to IDLE.
- `ota_out` passes through a 2-flop synchronizer. The synchronizer runs in all states.
- `start` outside IDLE is ignored.
- `ch_mask` changes during a sweep have no effect until the next reload.

## Timing
- Reset (asynchronous, takes effect immediately):
  - Outputs: `ota_en`=0, `ota_sel`=0, `res_valid`=0, `res_ch`=0, `res_bit`=0, `res_ones`=0, `busy`=0.
  - Internal: state IDLE, synchronizer flops and `mask_q` cleared.
  - Reset mid-conversion discards the result with no partial output.
- Cycle numbering: `start` sampled high at edge 0 gives state SETTLE from edge 0, with `ota_en`=1 and `busy`=1 visible in cycle 1.
- Samples are taken at edges `SETTLE`+1 .. `SETTLE`+`NSAMP`.
- `res_valid` rises in the cycle after the last sample: cycle `SETTLE`+`NSAMP`+1 counted from the SETTLE entry edge.
- Per-channel period with `res_ready` tied high: `SETTLE`+`NSAMP`+1 cycles.
- Back-to-back channels: the handshake edge is also the SETTLE entry edge for the next channel. `ota_en` is low for exactly one cycle per REPORT when ready is high.
- Backpressure: REPORT holds indefinitely and `ota_en` stays 0 while waiting.
- `res_valid` never drops without a handshake, except on reset.
- Width rules:
  - `ones` saturation is impossible, since `NSAMP` ≤ 15.
  - The settle counter is clog2(`SETTLE`+1) bits wide.

## Structure
- Package `digiota_pkg`: state enum `scan_state_t` (IDLE, SETTLE, SAMPLE, REPORT) and the default `NCH`/`SETTLE`/`NSAMP` constants.
- Sub-module `digiota_sync2`: 2-flop synchronizer with asynchronous active-high reset to 0, reusable for other async inputs.
- Next-channel logic is a priority encoder over `mask_q` & (~0 << (`cur`+1)), kept inside the block.

## Test plan
- Default parameters, mask 4'b1011, `ota_out`=1, ready high, `cont`=0:
  - Results in order: ch0, ch1, ch3, each `res_bit`=1, `res_ones`=5.
  - `res_valid` at cycles 9, 18, 27; then IDLE with `busy`=0.
- `ota_out` pattern 1,0,1,0,0 across the sample window:
  - `res_ones`=2, `res_bit`=0.
  - Pattern 1,1,0,1,0 gives `res_ones`=3, `res_bit`=1.
- `res_ready` held low 20 cycles in REPORT:
  - `res_valid`, `res_ch`, `res_bit` stable and `ota_en`=0 throughout.
  - Next channel SETTLE begins on the handshake edge.
- `cont`=1 with mask 4'b0100:
  - Repeated ch2 results every 9 cycles.
  - Mask changed to 0 mid-sweep: one more ch2 result, then IDLE.
- `start` with mask 0: no state change, `busy` stays 0.
  - `start` pulsed during SAMPLE: ignored.
- `rst` asserted in SAMPLE:
  - All outputs at reset values immediately.
  - After release, a new `start` produces a full, correct conversion.
